// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C EEPROM-style target: FSM states and default address.
package i2c_target_pkg;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        ACK_DEV,
        ADDR_H,
        ACK_H,
        ADDR_L,
        ACK_L,
        WR_DATA,
        ACK_WR,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchronizers plus SCL edge and START/STOP condition pulses.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Synchronizer chains (idle bus level is high) and one-cycle-delayed copies for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync[0] <= i_scl;
            r_sda_sync[0] <= i_sda;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_scl_sync[k] <= r_scl_sync[k-1];
                r_sda_sync[k] <= r_sda_sync[k-1];
            end
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = r_scl_d & w_scl & r_sda_d & ~w_sda;
    assign o_stop     = r_scl_d & w_scl & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_target_eeprom.sv
// I2C target with 16-bit address pointer, byte write strobes and sequential reads.
module i2c_target_eeprom
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_sda_oe,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_re,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_busy,
    output logic        o_start_det,
    output logic        o_stop_det
);

    logic w_sda, w_rise, w_fall, w_start, w_stop;
    logic [2:0] w_rd_idx;

    state_t      r_state, n_state;
    logic [3:0]  r_bit_cnt, n_bit_cnt;
    logic [7:0]  r_shift, n_shift;
    logic [7:0]  r_addr_h, n_addr_h;
    logic        r_rw, n_rw;
    logic        r_match, n_match;
    logic        r_sda_oe, n_sda_oe;
    logic [15:0] r_mem_addr, n_mem_addr;
    logic        r_mem_we, n_mem_we;
    logic [7:0]  r_mem_wdata, n_mem_wdata;
    logic        r_mem_re, n_mem_re;
    logic        r_rd_req, n_rd_req;
    logic        r_rd_load, n_rd_load;
    logic        r_inc, n_inc;
    logic        r_start_det, r_stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // Read bit index: after k bits have been clocked out, bit 7-k is next
    assign w_rd_idx = 3'd7 - r_bit_cnt[2:0];

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_addr_h    <= '0;
            r_rw        <= 1'b0;
            r_match     <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_load   <= 1'b0;
            r_inc       <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_state     <= n_state;
            r_bit_cnt   <= n_bit_cnt;
            r_shift     <= n_shift;
            r_addr_h    <= n_addr_h;
            r_rw        <= n_rw;
            r_match     <= n_match;
            r_sda_oe    <= n_sda_oe;
            r_mem_addr  <= n_mem_addr;
            r_mem_we    <= n_mem_we;
            r_mem_wdata <= n_mem_wdata;
            r_mem_re    <= n_mem_re;
            r_rd_req    <= n_rd_req;
            r_rd_load   <= n_rd_load;
            r_inc       <= n_inc;
            r_start_det <= w_start;
            r_stop_det  <= w_stop;
        end
    end

    // Next-state and datapath updates; START/STOP override bit processing in every state
    always_comb begin
        n_state     = r_state;
        n_bit_cnt   = r_bit_cnt;
        n_shift     = r_shift;
        n_addr_h    = r_addr_h;
        n_rw        = r_rw;
        n_match     = r_match;
        n_sda_oe    = r_sda_oe;
        n_mem_addr  = r_mem_addr;
        n_mem_we    = 1'b0;
        n_mem_wdata = r_mem_wdata;
        n_mem_re    = r_rd_req;
        n_rd_req    = 1'b0;
        n_rd_load   = r_mem_re;
        n_inc       = 1'b0;

        // Post-strobe pipeline: pointer increment after a write, read data capture after a read
        if (r_inc)
            n_mem_addr = r_mem_addr + 16'd1;
        if (r_rd_load)
            n_shift = i_mem_rdata;

        if (w_start) begin
            n_state   = DEVADDR;
            n_bit_cnt = '0;
            n_sda_oe  = 1'b0;
        end else if (w_stop) begin
            n_state  = IDLE;
            n_sda_oe = 1'b0;
        end else begin
            unique case (r_state)
                IDLE, WAIT_STOP: ;
                DEVADDR: begin
                    if (w_rise) begin
                        n_shift   = {r_shift[6:0], w_sda};
                        n_bit_cnt = r_bit_cnt + 4'd1;
                        // Match/direction are latched here so the shift register is free for read data
                        if (r_bit_cnt == 4'd7) begin
                            n_match  = (r_shift[6:0] == DEV_ADDR);
                            n_rw     = w_sda;
                            n_mem_re = (r_shift[6:0] == DEV_ADDR) && w_sda;
                        end
                    end else if (w_fall && r_bit_cnt == 4'd8) begin
                        n_state  = r_match ? ACK_DEV : WAIT_STOP;
                        n_sda_oe = r_match;
                    end
                end
                ACK_DEV: begin
                    if (w_fall) begin
                        n_bit_cnt = '0;
                        n_state   = r_rw ? RD_DATA : ADDR_H;
                        n_sda_oe  = r_rw ? ~r_shift[7] : 1'b0;
                    end
                end
                ADDR_H, ADDR_L, WR_DATA: begin
                    if (w_rise) begin
                        n_shift   = {r_shift[6:0], w_sda};
                        n_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_fall && r_bit_cnt == 4'd8) begin
                        n_sda_oe = 1'b1;
                        n_state  = (r_state == ADDR_H) ? ACK_H :
                                   (r_state == ADDR_L) ? ACK_L : ACK_WR;
                    end
                end
                ACK_H: begin
                    if (w_fall) begin
                        n_addr_h  = r_shift;
                        n_state   = ADDR_L;
                        n_bit_cnt = '0;
                        n_sda_oe  = 1'b0;
                    end
                end
                ACK_L: begin
                    if (w_fall) begin
                        n_mem_addr = {r_addr_h, r_shift};
                        n_state    = WR_DATA;
                        n_bit_cnt  = '0;
                        n_sda_oe   = 1'b0;
                    end
                end
                ACK_WR: begin
                    if (w_fall) begin
                        n_mem_we    = 1'b1;
                        n_mem_wdata = r_shift;
                        n_inc       = 1'b1;
                        n_state     = WR_DATA;
                        n_bit_cnt   = '0;
                        n_sda_oe    = 1'b0;
                    end
                end
                RD_DATA: begin
                    if (w_rise) begin
                        n_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            n_state  = RD_ACK;
                            n_sda_oe = 1'b0;
                        end else begin
                            n_sda_oe = ~r_shift[w_rd_idx];
                        end
                    end
                end
                RD_ACK: begin
                    // A fall here can only follow an ACK rise, since NACK leaves the state at the rise
                    if (w_rise) begin
                        if (w_sda) begin
                            n_state = WAIT_STOP;
                        end else begin
                            n_mem_addr = r_mem_addr + 16'd1;
                            n_rd_req   = 1'b1;
                        end
                    end else if (w_fall) begin
                        n_state   = RD_DATA;
                        n_bit_cnt = '0;
                        n_sda_oe  = ~r_shift[7];
                    end
                end
                default: n_state = IDLE;
            endcase
        end
    end

    assign o_sda_oe    = r_sda_oe;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_re    = r_mem_re;
    assign o_busy      = (r_state != IDLE);
    assign o_start_det = r_start_det;
    assign o_stop_det  = r_stop_det;

endmodule

// File: tb/tb_i2c_target_eeprom.sv
// Directed bench for i2c_target_eeprom: bus-level master, memory model, strobe monitors.
module tb_i2c_target_eeprom;

    localparam int Q = 80;  // quarter SCL period; i_clk period is 10

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_line;
    logic        o_sda_oe;
    logic [15:0] o_mem_addr;
    logic        o_mem_we;
    logic [7:0]  o_mem_wdata;
    logic        o_mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        o_busy;
    logic        o_start_det;
    logic        o_stop_det;

    logic [7:0]  mem [0:65535];
    logic [15:0] we_addr [$];
    logic [7:0]  we_data [$];
    int          re_cnt = 0;
    int          start_cnt = 0;
    int          stop_cnt = 0;
    logic        oe_seen = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic        ack;
    logic [7:0]  rd;

    assign sda_line = m_sda & ~o_sda_oe;

    always #5 clk = ~clk;

    i2c_target_eeprom #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_scl       (m_scl),
        .i_sda       (sda_line),
        .o_sda_oe    (o_sda_oe),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_re    (o_mem_re),
        .i_mem_rdata (mem_rdata),
        .o_busy      (o_busy),
        .o_start_det (o_start_det),
        .o_stop_det  (o_stop_det)
    );

    // Memory model: read data one clock after the strobe, writes captured at the strobe
    always @(posedge clk) begin
        if (o_mem_re) mem_rdata <= mem[o_mem_addr];
        if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    end

    // Strobe and pulse monitors sampled on the inactive edge
    always @(negedge clk) begin
        if (o_mem_we) begin
            we_addr.push_back(o_mem_addr);
            we_data.push_back(o_mem_wdata);
        end
        if (o_mem_re)    re_cnt++;
        if (o_start_det) start_cnt++;
        if (o_stop_det)  stop_cnt++;
        if (o_sda_oe)    oe_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        we_addr.delete();
        we_data.delete();
        re_cnt = 0;
        start_cnt = 0;
        stop_cnt = 0;
        oe_seen = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        m_sda = b;    #Q;
        m_scl = 1'b1; #Q;
        s = sda_line; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, s);
        a = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(~master_ack, s);
    endtask

    initial begin
        // Reset state
        #52;
        check("rst_sda_oe", o_sda_oe, 0);
        check("rst_busy", o_busy, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_we", o_mem_we, 0);
        check("rst_re", o_mem_re, 0);
        check("rst_wdata", o_mem_wdata, 0);
        check("rst_start_det", o_start_det, 0);
        check("rst_stop_det", o_stop_det, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        repeat (4) @(posedge clk);
        #2;

        // Write 0xDE,0xAD starting at 0x1234
        clear_mon();
        i2c_start();
        check("wr_busy", o_busy, 1);
        write_byte(8'hA0, ack); check("wr_ack_dev", ack, 1);
        write_byte(8'h12, ack); check("wr_ack_h", ack, 1);
        write_byte(8'h34, ack); check("wr_ack_l", ack, 1);
        check("wr_addr_loaded", o_mem_addr, 16'h1234);
        write_byte(8'hDE, ack); check("wr_ack_d0", ack, 1);
        write_byte(8'hAD, ack); check("wr_ack_d1", ack, 1);
        i2c_stop();
        check("wr_we_count", we_addr.size(), 2);
        if (we_addr.size() == 2) begin
            check("wr_we0_addr", we_addr[0], 16'h1234);
            check("wr_we0_data", we_data[0], 8'hDE);
            check("wr_we1_addr", we_addr[1], 16'h1235);
            check("wr_we1_data", we_data[1], 8'hAD);
        end
        check("wr_addr_end", o_mem_addr, 16'h1236);
        check("wr_start_cnt", start_cnt, 1);
        check("wr_stop_cnt", stop_cnt, 1);
        check("wr_busy_end", o_busy, 0);

        // Random read of 0x10..0x12
        mem[16'h0010] = 8'h11;
        mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33;
        clear_mon();
        i2c_start();
        write_byte(8'hA0, ack); check("rd_ack_dev_w", ack, 1);
        write_byte(8'h00, ack); check("rd_ack_h", ack, 1);
        write_byte(8'h10, ack); check("rd_ack_l", ack, 1);
        i2c_start();
        write_byte(8'hA1, ack); check("rd_ack_dev_r", ack, 1);
        read_byte(1'b1, rd); check("rd_byte0", rd, 8'h11);
        read_byte(1'b1, rd); check("rd_byte1", rd, 8'h22);
        read_byte(1'b0, rd); check("rd_byte2", rd, 8'h33);
        i2c_stop();
        check("rd_addr_end", o_mem_addr, 16'h0012);
        check("rd_re_count", re_cnt, 3);
        check("rd_we_count", we_addr.size(), 0);
        check("rd_start_cnt", start_cnt, 2);

        // Address mismatch
        clear_mon();
        i2c_start();
        write_byte(8'hA2, ack); check("mm_nack", ack, 0);
        write_byte(8'h55, ack); check("mm_nack2", ack, 0);
        i2c_stop();
        check("mm_oe_seen", oe_seen, 0);
        check("mm_we_count", we_addr.size(), 0);
        check("mm_re_count", re_cnt, 0);
        check("mm_busy", o_busy, 0);

        // Pointer wrap on write
        clear_mon();
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'hFF, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h5A, ack); check("wrap_ack0", ack, 1);
        write_byte(8'h6B, ack); check("wrap_ack1", ack, 1);
        i2c_stop();
        check("wrap_we_count", we_addr.size(), 2);
        if (we_addr.size() == 2) begin
            check("wrap_we0_addr", we_addr[0], 16'hFFFF);
            check("wrap_we0_data", we_data[0], 8'h5A);
            check("wrap_we1_addr", we_addr[1], 16'h0000);
            check("wrap_we1_data", we_data[1], 8'h6B);
        end
        check("wrap_addr_end", o_mem_addr, 16'h0001);

        // Abort: STOP after 5 data bits
        clear_mon();
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        write_byte(8'h20, ack);
        for (int i = 0; i < 5; i++) bit_cycle(1'b1, ack);
        i2c_stop();
        check("abort_we_count", we_addr.size(), 0);
        check("abort_busy", o_busy, 0);
        check("abort_stop_cnt", stop_cnt, 1);
        check("abort_addr", o_mem_addr, 16'h0020);

        // Reset asserted while driving a read bit low
        mem[16'h0020] = 8'h00;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        write_byte(8'h20, ack);
        i2c_start();
        write_byte(8'hA1, ack); check("rr_ack_dev", ack, 1);
        check("rr_oe_driving", o_sda_oe, 1);
        #1 rst_n = 1'b0;
        #1 check("rr_oe_reset", o_sda_oe, 0);
        check("rr_busy_reset", o_busy, 0);
        check("rr_addr_reset", o_mem_addr, 0);
        #30 rst_n = 1'b1;
        @(posedge clk); #2;
        i2c_stop();
        check("rr_idle_after", o_busy, 0);

        // Next transactions complete normally
        clear_mon();
        i2c_start();
        write_byte(8'hA0, ack); check("post_ack_dev", ack, 1);
        write_byte(8'h00, ack);
        write_byte(8'h30, ack);
        write_byte(8'h77, ack); check("post_ack_d", ack, 1);
        i2c_stop();
        check("post_we_count", we_addr.size(), 1);
        if (we_addr.size() == 1) begin
            check("post_we_addr", we_addr[0], 16'h0030);
            check("post_we_data", we_data[0], 8'h77);
        end
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        write_byte(8'h30, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        read_byte(1'b0, rd); check("post_rd", rd, 8'h77);
        i2c_stop();
        check("post_addr_end", o_mem_addr, 16'h0030);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
